writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//  EXE->WB pipeline register and register-file write port driver for the 128-bit SIMD pipe.
//  Captures ALU result + 25-bit instruction, decodes regWrite, drives the register file's write side.
//  Optionally bypasses the WB result into the ID-stage operand reads (same-cycle write/read hazard).
//  Counts retired register-writing instructions.
// PARAMETERS
//  DATA_W   128  datapath width (four 32-bit lanes)
//  INSTR_W  25   instruction width
//  CNT_W    32   retire counter width
// PORTS
//  clk            in   1        clock
//  reset          in   1        synchronous, active-high reset
//  alu_out_exe    in   DATA_W   ALU result from EXE
//  instr_exe      in   INSTR_W  instruction in EXE
//  valid_exe      in   1        EXE slot holds a real instruction
//  stall          in   1        hold WB register contents
//  flush          in   1        replace next WB contents with bubble
//  alu_out_wb     out  DATA_W   write data to register file
//  instr_wb       out  INSTR_W  instruction to register file (0 = bubble)
//  reg_write_wb   out  1        register file write enable
//  wb_dest        out  5        instr_wb[4:0]
//  instr_id       in   INSTR_W  instruction in ID (source field select)
//  rs1_rf,rs2_rf,rs3_rf,rd_rf  in  DATA_W each  raw register file reads
//  rs1_id,rs2_id,rs3_id,rd_id  out DATA_W each  operands after bypass
//  fwd_hit        out  4        {rd,rs3,rs2,rs1} bypass taken this cycle
//  retire_count   out  CNT_W    retired register writes, saturating
// BEHAVIOUR
//  - Registered on posedge clk; reset, clk as above. Priority: reset > flush > stall > capture.
//  - reset: alu_out_wb=0, instr_wb=0, valid_wb=0, retire_count=0. Reset mid-stall/flush wins.
//  - flush: instr_wb<=0, alu_out_wb<=0, valid_wb<=0 (bubble); flush with stall => bubble.
//  - stall (no flush): all WB state held; register file rewrites same data (idempotent).
//  - capture: instr_wb<=valid_exe?instr_exe:0; alu_out_wb<=alu_out_exe; valid_wb<=valid_exe.
//  - Latency: EXE->WB outputs 1 cycle; register file updated on the following edge.
//  - reg_write_wb (comb) = valid_wb && instr_wb!=0 && (instr_wb[24:23]!=2'b11 || instr_wb[19:15]!=0).
//    instr_wb[24:23]==3 with [19:15]==0 is a no-write op (e.g. nop class).
//  - All 32 destinations writable, including r0; no hardwired zero.
//  - retire_count increments when reg_write_wb && !stall && !flush && !reset; saturates at all-ones.
//  - Field map (ID): rs1=[9:5], rs2=[14:10], rs3=[19:15], rd=[4:0].
// CONFIGURATION
//  WB_FWD_EN defined: per operand, if reg_write_wb && wb_dest==field(instr_id) then operand=alu_out_wb,
//    matching fwd_hit bit=1; else operand=*_rf, bit=0. Multiple operands may hit simultaneously.
//  WB_FWD_EN undefined: rs*_id/rd_id = *_rf pass-through; fwd_hit=4'b0000; compare logic absent.
// STRUCTURE
//  simd_pkg: DATA_W/INSTR_W constants, instr field index localparams, typedef instr_t,
//    function is_reg_write(instr_t) shared with the register file.
//  Sub-module wb_bypass_mux (one per operand, x4): field, wb_dest, reg_write_wb, rf data, wb data
//    -> operand, hit. Instantiated only under WB_FWD_EN.
// TESTING
//  1 reset held 2 cycles with valid_exe=1 -> instr_wb=0, reg_write_wb=0, retire_count=0.
//  2 instr_exe=25'h000_0043 (rd=3), alu_out_exe=128'hA5.., valid_exe=1 -> next cycle reg_write_wb=1,
//    wb_dest=3, alu_out_wb=128'hA5..; retire_count 0->1 on following edge.
//  3 instr_exe[24:23]=2'b11,[19:15]=0 -> reg_write_wb=0, count unchanged; same with [19:15]=5 -> 1.
//  4 stall=1 for 3 cycles with new EXE data -> WB held, count +1 only after stall drops; flush+stall -> bubble.
//  5 WB_FWD_EN: WB dest=7, instr_id rs1=7, rs3=7 -> rs1_id=rs3_id=alu_out_wb, fwd_hit=4'b0101;
//    without macro -> *_rf values, fwd_hit=0.
//  6 force retire_count to max via 2^CNT_W writes (CNT_W=4 build) -> holds at 4'hF.

Source files
------------

// File: rtl/simd_pkg.sv
// -----------------------------------------------------------------------------
// simd_pkg
//   Shared constants, types and decode helpers for the 128-bit SIMD pipe.
//   The register file uses is_reg_write() too. That keeps the WB-stage write
//   enable and the register file's own decode identical.
//
//   Contents:
//     DATA_W, INSTR_W, CNT_W    default widths
//     *_LSB                     instruction field positions (5-bit register fields)
//     instr_t, reg_idx_t        instruction / register index types
//     is_reg_write(instr)       1 when a non-bubble instruction writes a register
// -----------------------------------------------------------------------------
package simd_pkg;

    localparam int DATA_W    = 128;
    localparam int INSTR_W   = 25;
    localparam int CNT_W     = 32;
    localparam int REG_IDX_W = 5;

    // Field map of the instruction word
    localparam int RD_LSB  = 0;
    localparam int RS1_LSB = 5;
    localparam int RS2_LSB = 10;
    localparam int RS3_LSB = 15;
    localparam int OP_MSB  = 24;
    localparam int OP_LSB  = 23;

    // Opcode class that does not write when its rs3 field is zero (nop class)
    localparam logic [1:0] OP_NOWRITE_CLASS = 2'b11;

    typedef logic [INSTR_W-1:0]   instr_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // An all-zero word is the bubble encoding. Opcode class 2'b11 with rs3 == 0
    // is a no-write op. Every other instruction writes rd, and r0 is a normal
    // writable register.
    function automatic logic is_reg_write(input instr_t instr);
        return (instr != '0) &&
               ((instr[OP_MSB:OP_LSB] != OP_NOWRITE_CLASS) ||
                (instr[RS3_LSB +: REG_IDX_W] != '0));
    endfunction

endpackage

// File: rtl/wb_bypass_mux.sv
// -----------------------------------------------------------------------------
// wb_bypass_mux
//   Forwards one ID-stage operand. If the WB stage is writing the register that
//   this operand reads, the WB result replaces the raw register-file read.
//   Without this, the read would return stale data in the cycle of the write.
//
//   Ports:
//     field         in   5        source register index from the ID instruction
//     wb_dest       in   5        destination index of the WB instruction
//     reg_write_wb  in   1        WB instruction writes the register file
//     rf_data       in   DATA_W   raw register file read
//     wb_data       in   DATA_W   WB write data
//     operand       out  DATA_W   operand after bypass
//     hit           out  1        bypass taken
// -----------------------------------------------------------------------------
module wb_bypass_mux
    import simd_pkg::*;
#(
    parameter int DATA_W = simd_pkg::DATA_W
) (
    input  logic [REG_IDX_W-1:0] field,
    input  logic [REG_IDX_W-1:0] wb_dest,
    input  logic                 reg_write_wb,
    input  logic [DATA_W-1:0]    rf_data,
    input  logic [DATA_W-1:0]    wb_data,
    output logic [DATA_W-1:0]    operand,
    output logic                 hit
);

    assign hit     = reg_write_wb && (wb_dest == field);
    assign operand = hit ? wb_data : rf_data;

endmodule

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//   EXE->WB pipeline register and register-file write-port driver for the
//   128-bit SIMD pipe. It also counts retired register-writing instructions.
//
//   Optional feature (macro WB_FWD_EN): bypasses the WB result into the ID-stage
//   operand reads for same-cycle write/read hazards. With the macro undefined,
//   the operands pass straight through from the register file and fwd_hit is 0.
//
//   Flow control: valid_exe marks a real instruction in the EXE slot. stall
//   acts as the WB not-ready signal. A transfer from EXE into WB happens on a
//   clock edge where stall and flush are both low. While stall is high, WB
//   holds its contents and the register file rewrites the same data (harmless).
//   flush overrides stall and loads a bubble. reset overrides everything.
//
//   Ports:
//     clk, reset                  clock, synchronous active-high reset
//     alu_out_exe, instr_exe      EXE result / instruction
//     valid_exe, stall, flush     slot valid, hold, bubble-insert
//     alu_out_wb, instr_wb        register file write data / instruction
//     reg_write_wb, wb_dest       register file write enable / index
//     instr_id                    ID instruction (source field select)
//     rs1_rf..rd_rf               raw register file reads
//     rs1_id..rd_id               operands after bypass
//     fwd_hit                     {rd,rs3,rs2,rs1} bypass taken
//     retire_count                saturating retired-write counter
// -----------------------------------------------------------------------------
module writeback_stage
    import simd_pkg::*;
#(
    parameter int DATA_W  = simd_pkg::DATA_W,
    parameter int INSTR_W = simd_pkg::INSTR_W,
    parameter int CNT_W   = simd_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  alu_out_exe,
    input  logic [INSTR_W-1:0] instr_exe,
    input  logic               valid_exe,
    input  logic               stall,
    input  logic               flush,
    output logic [DATA_W-1:0]  alu_out_wb,
    output logic [INSTR_W-1:0] instr_wb,
    output logic               reg_write_wb,
    output logic [4:0]         wb_dest,
    input  logic [INSTR_W-1:0] instr_id,
    input  logic [DATA_W-1:0]  rs1_rf,
    input  logic [DATA_W-1:0]  rs2_rf,
    input  logic [DATA_W-1:0]  rs3_rf,
    input  logic [DATA_W-1:0]  rd_rf,
    output logic [DATA_W-1:0]  rs1_id,
    output logic [DATA_W-1:0]  rs2_id,
    output logic [DATA_W-1:0]  rs3_id,
    output logic [DATA_W-1:0]  rd_id,
    output logic [3:0]         fwd_hit,
    output logic [CNT_W-1:0]   retire_count
);

    logic valid_wb;

    // ---------------- WB pipeline register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_out_wb <= '0;
            instr_wb   <= '0;
            valid_wb   <= 1'b0;
        end else if (flush) begin
            alu_out_wb <= '0;
            instr_wb   <= '0;
            valid_wb   <= 1'b0;
        end else if (!stall) begin
            // An invalid EXE slot becomes the all-zero bubble instruction.
            instr_wb   <= valid_exe ? instr_exe : '0;
            alu_out_wb <= alu_out_exe;
            valid_wb   <= valid_exe;
        end
    end

    assign reg_write_wb = valid_wb && is_reg_write(instr_wb);
    assign wb_dest      = instr_wb[RD_LSB +: REG_IDX_W];

    // ---------------- retire counter ----------------
    // A WB instruction counts once, on the edge where it leaves WB. A stalled
    // instruction is counted when the stall drops. A flushed one is never counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_count <= '0;
        end else if (reg_write_wb && !stall && !flush && (retire_count != '1)) begin
            retire_count <= retire_count + CNT_W'(1);
        end
    end

    // ---------------- ID operand bypass ----------------
`ifdef WB_FWD_EN
    logic [REG_IDX_W-1:0] id_field [4];
    logic [DATA_W-1:0]    rf_data  [4];
    logic [DATA_W-1:0]    op_data  [4];

    // Index order matches fwd_hit bits: 0=rs1, 1=rs2, 2=rs3, 3=rd
    assign id_field[0] = instr_id[RS1_LSB +: REG_IDX_W];
    assign id_field[1] = instr_id[RS2_LSB +: REG_IDX_W];
    assign id_field[2] = instr_id[RS3_LSB +: REG_IDX_W];
    assign id_field[3] = instr_id[RD_LSB  +: REG_IDX_W];

    assign rf_data[0] = rs1_rf;
    assign rf_data[1] = rs2_rf;
    assign rf_data[2] = rs3_rf;
    assign rf_data[3] = rd_rf;

    for (genvar g = 0; g < 4; g++) begin : g_bypass
        wb_bypass_mux #(
            .DATA_W(DATA_W)
        ) u_mux (
            .field       (id_field[g]),
            .wb_dest     (wb_dest),
            .reg_write_wb(reg_write_wb),
            .rf_data     (rf_data[g]),
            .wb_data     (alu_out_wb),
            .operand     (op_data[g]),
            .hit         (fwd_hit[g])
        );
    end

    assign rs1_id = op_data[0];
    assign rs2_id = op_data[1];
    assign rs3_id = op_data[2];
    assign rd_id  = op_data[3];
`else
    // Without forwarding, instr_id is not needed.
    logic unused_instr_id;
    assign unused_instr_id = ^instr_id;

    assign rs1_id  = rs1_rf;
    assign rs2_id  = rs2_rf;
    assign rs3_id  = rs3_rf;
    assign rd_id   = rd_rf;
    assign fwd_hit = 4'b0000;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_writeback_stage
//   Directed bench for writeback_stage, built with CNT_W=4 so that counter
//   saturation can be reached. The driver applies one vector per cycle and
//   pushes the expected post-edge outputs into exp_q. A monitor pops exp_q
//   and compares just after every rising edge. A few hand-computed values are
//   also checked at fixed points. Works with and without WB_FWD_EN.
// -----------------------------------------------------------------------------
module tb_writeback_stage;

    localparam int DW = 128;
    localparam int IW = 25;
    localparam int CW = 4;

`ifdef WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [DW-1:0] RS1_RF_V = {4{32'h1111_1111}};
    localparam logic [DW-1:0] RS2_RF_V = {4{32'h2222_2222}};
    localparam logic [DW-1:0] RS3_RF_V = {4{32'h3333_3333}};
    localparam logic [DW-1:0] RD_RF_V  = {4{32'h4444_4444}};
    localparam logic [DW-1:0] ALU_A5   = {16{8'hA5}};
    localparam logic [DW-1:0] ALU_9F   = {4{32'h9F9F_0102}};

    logic          clk;
    logic          reset;
    logic [DW-1:0] alu_out_exe;
    logic [IW-1:0] instr_exe;
    logic          valid_exe;
    logic          stall;
    logic          flush;
    logic [DW-1:0] alu_out_wb;
    logic [IW-1:0] instr_wb;
    logic          reg_write_wb;
    logic [4:0]    wb_dest;
    logic [IW-1:0] instr_id;
    logic [DW-1:0] rs1_rf, rs2_rf, rs3_rf, rd_rf;
    logic [DW-1:0] rs1_id, rs2_id, rs3_id, rd_id;
    logic [3:0]    fwd_hit;
    logic [CW-1:0] retire_count;

    writeback_stage #(
        .DATA_W (DW),
        .INSTR_W(IW),
        .CNT_W  (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .alu_out_exe (alu_out_exe),
        .instr_exe   (instr_exe),
        .valid_exe   (valid_exe),
        .stall       (stall),
        .flush       (flush),
        .alu_out_wb  (alu_out_wb),
        .instr_wb    (instr_wb),
        .reg_write_wb(reg_write_wb),
        .wb_dest     (wb_dest),
        .instr_id    (instr_id),
        .rs1_rf      (rs1_rf),
        .rs2_rf      (rs2_rf),
        .rs3_rf      (rs3_rf),
        .rd_rf       (rd_rf),
        .rs1_id      (rs1_id),
        .rs2_id      (rs2_id),
        .rs3_id      (rs3_id),
        .rd_id       (rd_id),
        .fwd_hit     (fwd_hit),
        .retire_count(retire_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [DW-1:0] alu;
        logic [IW-1:0] instr;
        logic          rw;
        logic [4:0]    dest;
        logic [CW-1:0] cnt;
        logic [3:0]    hit;
        logic [DW-1:0] rs1, rs2, rs3, rd;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bench-side reference state of the WB stage
    logic [DW-1:0] m_alu;
    logic [IW-1:0] m_instr;
    logic          m_valid;
    logic [CW-1:0] m_cnt;

    function automatic logic model_writes(input logic [IW-1:0] ins, input logic vld);
        if (!vld)       return 1'b0;
        if (ins == '0)  return 1'b0;
        if (ins[24] && ins[23] && (ins[19:15] == 5'd0)) return 1'b0;
        return 1'b1;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic rst, input logic vld, input logic [IW-1:0] ins,
                        input logic [DW-1:0] alu, input logic stl, input logic fl,
                        input logic [IW-1:0] iid);
        exp_t e;
        logic pre;
        @(negedge clk);
        reset       = rst;
        valid_exe   = vld;
        instr_exe   = ins;
        alu_out_exe = alu;
        stall       = stl;
        flush       = fl;
        instr_id    = iid;

        pre = model_writes(m_instr, m_valid);
        if (rst)                                         m_cnt = '0;
        else if (pre && !stl && !fl && m_cnt != 4'hF)    m_cnt = m_cnt + 4'd1;
        if (rst || fl) begin
            m_alu = '0; m_instr = '0; m_valid = 1'b0;
        end else if (!stl) begin
            m_instr = vld ? ins : '0;
            m_alu   = alu;
            m_valid = vld;
        end

        e.alu    = m_alu;
        e.instr  = m_instr;
        e.rw     = model_writes(m_instr, m_valid);
        e.dest   = m_instr[4:0];
        e.cnt    = m_cnt;
        e.hit[0] = FWD && e.rw && (iid[9:5]   == e.dest);
        e.hit[1] = FWD && e.rw && (iid[14:10] == e.dest);
        e.hit[2] = FWD && e.rw && (iid[19:15] == e.dest);
        e.hit[3] = FWD && e.rw && (iid[4:0]   == e.dest);
        e.rs1    = e.hit[0] ? m_alu : RS1_RF_V;
        e.rs2    = e.hit[1] ? m_alu : RS2_RF_V;
        e.rs3    = e.hit[2] ? m_alu : RS3_RF_V;
        e.rd     = e.hit[3] ? m_alu : RD_RF_V;
        exp_q.push_back(e);
    endtask

    task automatic bubble();
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    // Wait until just after the capture edge of the last step
    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_alu_out_wb",   alu_out_wb,   e.alu);
                chk("sb_instr_wb",     DW'(instr_wb), DW'(e.instr));
                chk("sb_reg_write_wb", DW'(reg_write_wb), DW'(e.rw));
                chk("sb_wb_dest",      DW'(wb_dest), DW'(e.dest));
                chk("sb_retire_count", DW'(retire_count), DW'(e.cnt));
                chk("sb_fwd_hit",      DW'(fwd_hit), DW'(e.hit));
                chk("sb_rs1_id",       rs1_id, e.rs1);
                chk("sb_rs2_id",       rs2_id, e.rs2);
                chk("sb_rs3_id",       rs3_id, e.rs3);
                chk("sb_rd_id",        rd_id,  e.rd);
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1; valid_exe = 1'b1; instr_exe = 25'h000_0043; alu_out_exe = ALU_A5;
        stall = 1'b0; flush = 1'b0; instr_id = '0;
        rs1_rf = RS1_RF_V; rs2_rf = RS2_RF_V; rs3_rf = RS3_RF_V; rd_rf = RD_RF_V;
        m_alu = '0; m_instr = '0; m_valid = 1'b0; m_cnt = '0;

        // 1: reset held 2 cycles with a valid EXE instruction
        step(1'b1, 1'b1, 25'h000_0043, ALU_A5, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 25'h000_0043, ALU_A5, 1'b0, 1'b0, '0);
        after_edge();
        chk("rst_instr_wb",     DW'(instr_wb), '0);
        chk("rst_reg_write_wb", DW'(reg_write_wb), '0);
        chk("rst_retire_count", DW'(retire_count), '0);

        // 2: rd=3 write, 1-cycle latency, count moves on the following edge
        step(1'b0, 1'b1, 25'h000_0043, ALU_A5, 1'b0, 1'b0, '0);
        after_edge();
        chk("t2_reg_write_wb", DW'(reg_write_wb), DW'(1));
        chk("t2_wb_dest",      DW'(wb_dest), DW'(3));
        chk("t2_alu_out_wb",   alu_out_wb, ALU_A5);
        chk("t2_cnt_before",   DW'(retire_count), DW'(0));
        bubble();
        after_edge();
        chk("t2_cnt_after",    DW'(retire_count), DW'(1));

        // 3: no-write class, then the same class with rs3=5 (writes)
        step(1'b0, 1'b1, 25'h180_0025, {16{8'hC3}}, 1'b0, 1'b0, '0);
        after_edge();
        chk("t3_nowrite_rw", DW'(reg_write_wb), DW'(0));
        bubble();
        after_edge();
        chk("t3_nowrite_cnt", DW'(retire_count), DW'(1));
        step(1'b0, 1'b1, 25'h182_8025, {16{8'hC4}}, 1'b0, 1'b0, '0);
        after_edge();
        chk("t3_write_rw", DW'(reg_write_wb), DW'(1));
        bubble();

        // 4: stall 3 cycles with new EXE data, release, then flush+stall
        step(1'b0, 1'b1, 25'h000_0061, {16{8'h5A}}, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 25'h000_0042, {16{8'h77}}, 1'b1, 1'b0, '0);
        after_edge();
        chk("t4_stall_instr", DW'(instr_wb), DW'(25'h000_0061));
        chk("t4_stall_cnt",   DW'(retire_count), DW'(2));
        step(1'b0, 1'b1, 25'h000_0042, {16{8'h77}}, 1'b0, 1'b0, '0);
        after_edge();
        chk("t4_release_cnt", DW'(retire_count), DW'(3));
        step(1'b0, 1'b1, 25'h000_0044, {16{8'h88}}, 1'b1, 1'b1, '0);
        after_edge();
        chk("t4_flush_instr", DW'(instr_wb), '0);
        chk("t4_flush_cnt",   DW'(retire_count), DW'(3));

        // 5: WB dest=7, ID rs1=7 and rs3=7
        step(1'b0, 1'b1, 25'h000_0007, ALU_9F, 1'b0, 1'b0, 25'h003_80E0);
        after_edge();
        chk("t5_fwd_hit", DW'(fwd_hit), FWD ? DW'(4'b0101) : DW'(4'b0000));
        chk("t5_rs1_id",  rs1_id, FWD ? ALU_9F : RS1_RF_V);
        chk("t5_rs3_id",  rs3_id, FWD ? ALU_9F : RS3_RF_V);
        chk("t5_rs2_id",  rs2_id, RS2_RF_V);
        // r0 is an ordinary destination; an all-zero ID word matches every field
        step(1'b0, 1'b1, 25'h000_0400, {16{8'h3C}}, 1'b0, 1'b0, '0);
        after_edge();
        chk("t5_r0_rw",  DW'(reg_write_wb), DW'(1));
        chk("t5_r0_hit", DW'(fwd_hit), FWD ? DW'(4'b1111) : DW'(4'b0000));

        // 6: drive the 4-bit counter past its maximum
        for (int i = 0; i < 14; i++)
            step(1'b0, 1'b1, 25'h000_0043, DW'(i), 1'b0, 1'b0, 25'h000_0021);
        after_edge();
        chk("t6_saturated", DW'(retire_count), DW'(4'hF));

        // Reset during stall+flush clears everything
        step(1'b1, 1'b1, 25'h000_0043, ALU_A5, 1'b1, 1'b1, '0);
        after_edge();
        chk("t7_reset_cnt", DW'(retire_count), '0);
        bubble();

        // Drain with a bounded wait
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) after_edge();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
